systolic: RTL and testbench

- 2x2 weight-stationary systolic array of four MAC processing elements (pe11, pe12, pe21, pe22) computing C = A·W in signed Q8.8 fixed point.
- Activations enter on the left and flow right; weights enter on top and shift down into per-PE double-buffered weight registers; partial sums flow down.
- Results leave at the bottom of each column.
- Fed by the unified buffer; the buffer also supplies the active column count.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_pe.sv | 72 +++++++
 rtl/systolic.sv | 80 ++++++++
 tb/tb_systolic.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared fixed-point definitions for the 2x2 systolic array (signed Q8.8).
package systolic_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef logic signed [DATA_W-1:0] fixed16_t;

  function automatic fixed16_t to_fixed(input int value);
    return fixed16_t'(value <<< FRAC_W);
  endfunction

  function automatic int from_fixed(input fixed16_t value);
    return int'(value) >>> FRAC_W;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Single MAC cell: double-buffered weight, forwards activation/valid/switch/weight.
module pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter int FRAC_W = systolic_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_input,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_psum,
  input  logic [DATA_W-1:0] i_weight,
  input  logic              i_accept,
  input  logic              i_switch,
  output logic [DATA_W-1:0] o_input,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_psum,
  output logic [DATA_W-1:0] o_weight,
  output logic              o_switch
);

  logic [DATA_W-1:0]   weight_reg_inactive;
  logic [DATA_W-1:0]   weight_reg_active;
  logic [DATA_W-1:0]   pe_psum_out;
  logic [DATA_W-1:0]   pe_input_out;
  logic                r_valid_out;
  logic                r_switch_out;

  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_term;
  logic [DATA_W-1:0]   w_sum;
  logic                w_unused_prod;

  // Arithmetic shift then truncation keeps exactly this slice of the product.
  assign w_prod        = $signed(i_input) * $signed(weight_reg_active);
  assign w_term        = w_prod[FRAC_W +: DATA_W];
  assign w_sum         = i_psum + w_term;
  assign w_unused_prod = ^{w_prod[2*DATA_W-1:FRAC_W+DATA_W], w_prod[FRAC_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_reg_inactive <= '0;
      weight_reg_active   <= '0;
      pe_psum_out         <= '0;
      pe_input_out        <= '0;
      r_valid_out         <= 1'b0;
      r_switch_out        <= 1'b0;
    end else begin
      if (i_accept) weight_reg_inactive <= i_weight;
      if (i_switch) weight_reg_active   <= weight_reg_inactive;
      r_switch_out <= i_switch;
      if (i_valid) begin
        pe_input_out <= i_input;
        r_valid_out  <= i_enable;
        pe_psum_out  <= i_enable ? w_sum : '0;
      end else begin
        pe_input_out <= '0;
        r_valid_out  <= 1'b0;
        pe_psum_out  <= '0;
      end
    end
  end

  assign o_input  = pe_input_out;
  assign o_valid  = r_valid_out;
  assign o_psum   = pe_psum_out;
  assign o_weight = weight_reg_inactive;
  assign o_switch = r_switch_out;

endmodule

// File: rtl/systolic.sv
// 2x2 weight-stationary systolic array; activations flow right, psums flow down.
module systolic
  import systolic_pkg::*;
#(
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter int FRAC_W = systolic_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ub_rd_col_size_in,
  input  logic              ub_rd_col_size_valid_in,
  input  logic [DATA_W-1:0] sys_data_in_1x,
  input  logic [DATA_W-1:0] sys_data_in_2x,
  input  logic              sys_start,
  input  logic [DATA_W-1:0] sys_weight_in_x1,
  input  logic [DATA_W-1:0] sys_weight_in_x2,
  input  logic              sys_accept_w_1,
  input  logic              sys_accept_w_2,
  input  logic              sys_switch_in,
  output logic [DATA_W-1:0] sys_data_out_x1,
  output logic [DATA_W-1:0] sys_data_out_x2,
  output logic              sys_valid_out_x1,
  output logic              sys_valid_out_x2
);

  logic [15:0]       r_col_size;
  logic              w_en1, w_en2;

  logic [DATA_W-1:0] w_in11, w_psum11, w_wt11;
  logic              w_val11, w_sw11;
  logic [DATA_W-1:0] w_in21, w_psum12, w_wt12;
  logic              w_val21, w_sw12;

  logic [DATA_W-1:0] w_unused_in12, w_unused_in22, w_unused_wt21, w_unused_wt22;
  logic              w_unused_val12, w_unused_sw21, w_unused_sw22;

  always_ff @(posedge clk) begin
    if (rst)                          r_col_size <= '0;
    else if (ub_rd_col_size_valid_in) r_col_size <= ub_rd_col_size_in;
  end

  assign w_en1 = (r_col_size >= 16'd1);
  assign w_en2 = (r_col_size >= 16'd2);

  pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) pe11 (
    .clk(clk), .rst(rst), .i_enable(w_en1),
    .i_input(sys_data_in_1x), .i_valid(sys_start), .i_psum('0),
    .i_weight(sys_weight_in_x1), .i_accept(sys_accept_w_1), .i_switch(sys_switch_in),
    .o_input(w_in11), .o_valid(w_val11), .o_psum(w_psum11),
    .o_weight(w_wt11), .o_switch(w_sw11)
  );

  pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) pe12 (
    .clk(clk), .rst(rst), .i_enable(w_en2),
    .i_input(w_in11), .i_valid(w_val11), .i_psum('0),
    .i_weight(sys_weight_in_x2), .i_accept(sys_accept_w_2), .i_switch(w_sw11),
    .o_input(w_unused_in12), .o_valid(w_unused_val12), .o_psum(w_psum12),
    .o_weight(w_wt12), .o_switch(w_sw12)
  );

  pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) pe21 (
    .clk(clk), .rst(rst), .i_enable(w_en1),
    .i_input(sys_data_in_2x), .i_valid(w_val11), .i_psum(w_psum11),
    .i_weight(w_wt11), .i_accept(sys_accept_w_1), .i_switch(w_sw11),
    .o_input(w_in21), .o_valid(w_val21), .o_psum(sys_data_out_x1),
    .o_weight(w_unused_wt21), .o_switch(w_unused_sw21)
  );

  // Row-2 valid comes from pe11 rather than pe21's own feed, hence the caller skew.
  pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) pe22 (
    .clk(clk), .rst(rst), .i_enable(w_en2),
    .i_input(w_in21), .i_valid(w_val21), .i_psum(w_psum12),
    .i_weight(w_wt12), .i_accept(sys_accept_w_2), .i_switch(w_sw12),
    .o_input(w_unused_in22), .o_valid(sys_valid_out_x2), .o_psum(sys_data_out_x2),
    .o_weight(w_unused_wt22), .o_switch(w_unused_sw22)
  );

  assign sys_valid_out_x1 = w_val21;

endmodule

// File: tb/tb_systolic.sv
// Scoreboarded random/directed bench for the 2x2 systolic array.
module tb_systolic;
  import systolic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] col_size;
  logic        col_size_valid;
  logic [15:0] d1, d2, wt1, wt2;
  logic        start, acc1, acc2, sw;
  logic [15:0] out1, out2;
  logic        vout1, vout2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp1_q[$];
  logic [15:0] exp2_q[$];
  logic [15:0] ma[8][2];

  always #5 clk = ~clk;

  systolic #(.DATA_W(16), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst),
    .ub_rd_col_size_in(col_size), .ub_rd_col_size_valid_in(col_size_valid),
    .sys_data_in_1x(d1), .sys_data_in_2x(d2), .sys_start(start),
    .sys_weight_in_x1(wt1), .sys_weight_in_x2(wt2),
    .sys_accept_w_1(acc1), .sys_accept_w_2(acc2), .sys_switch_in(sw),
    .sys_data_out_x1(out1), .sys_data_out_x2(out2),
    .sys_valid_out_x1(vout1), .sys_valid_out_x2(vout2)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Q8.8 product: full-precision product scaled down by 256 (floor), kept mod 2^16.
  function automatic logic [15:0] fx_term(input logic [15:0] a, input logic [15:0] w);
    longint p;
    longint q;
    p = longint'($signed(a)) * longint'($signed(w));
    q = (p - ((p % 256 + 256) % 256)) / 256;
    return q[15:0];
  endfunction

  function automatic logic [15:0] ref_c(input logic [15:0] a0, input logic [15:0] a1,
                                        input logic [15:0] w0, input logic [15:0] w1);
    return fx_term(a0, w0) + fx_term(a1, w1);
  endfunction

  // Monitor: pop on each valid output; idle outputs must read zero.
  initial begin
    forever begin
      @(negedge clk);
      if (vout1) begin
        if (exp1_q.size() == 0) chk("col1_unexpected_valid", {15'd0, vout1}, 16'd0);
        else chk("col1_data", out1, exp1_q.pop_front());
      end else chk("col1_idle_zero", out1, 16'd0);
      if (vout2) begin
        if (exp2_q.size() == 0) chk("col2_unexpected_valid", {15'd0, vout2}, 16'd0);
        else chk("col2_data", out2, exp2_q.pop_front());
      end else chk("col2_idle_zero", out2, 16'd0);
    end
  end

  task automatic idle_inputs;
    col_size_valid = 1'b0; col_size = '0;
    d1 = '0; d2 = '0; wt1 = '0; wt2 = '0;
    start = 1'b0; acc1 = 1'b0; acc2 = 1'b0; sw = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out1"}, out1, 16'd0);
    chk({tag, "_out2"}, out2, 16'd0);
    chk({tag, "_valids"}, {14'd0, vout1, vout2}, 16'd0);
    chk({tag, "_pe11_inact"}, dut.pe11.weight_reg_inactive, 16'd0);
    chk({tag, "_pe11_act"},   dut.pe11.weight_reg_active,   16'd0);
    chk({tag, "_pe12_inact"}, dut.pe12.weight_reg_inactive, 16'd0);
    chk({tag, "_pe21_act"},   dut.pe21.weight_reg_active,   16'd0);
    chk({tag, "_pe22_act"},   dut.pe22.weight_reg_active,   16'd0);
    chk({tag, "_pe11_psum"},  dut.pe11.pe_psum_out,         16'd0);
    chk({tag, "_pe12_in"},    dut.pe12.pe_input_out,        16'd0);
  endtask

  // Load W (bottom row first, column 2 skewed by one), switch, stream n rows of ma.
  task automatic run_mm(input logic [15:0] w00, input logic [15:0] w01,
                        input logic [15:0] w10, input logic [15:0] w11,
                        input int unsigned n, input logic [15:0] csz);
    idle_inputs();
    col_size_valid = 1'b1; col_size = csz;
    acc1 = 1'b1; wt1 = w10;
    tick();
    col_size_valid = 1'b0;
    acc1 = 1'b1; wt1 = w00; acc2 = 1'b1; wt2 = w11;
    tick();
    acc1 = 1'b0; wt1 = '0; acc2 = 1'b1; wt2 = w01; sw = 1'b1;
    tick();
    idle_inputs();
    tick();
    for (int unsigned t = 0; t <= n; t++) begin
      start = (t < n);
      d1    = (t < n) ? ma[t][0] : 16'd0;
      d2    = (t >= 1) ? ma[t-1][1] : 16'd0;
      if (t < n) begin
        if (csz >= 16'd1) exp1_q.push_back(ref_c(ma[t][0], ma[t][1], w00, w10));
        if (csz >= 16'd2) exp2_q.push_back(ref_c(ma[t][0], ma[t][1], w01, w11));
      end
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    chk("col1_queue_drained", 16'(exp1_q.size()), 16'd0);
    chk("col2_queue_drained", 16'(exp2_q.size()), 16'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Directed weight-load and same-edge switch/accept.
    col_size_valid = 1'b1; col_size = 16'd2;
    acc1 = 1'b1; wt1 = 16'h05C0;
    tick();
    chk("ld_pe11_inact", dut.pe11.weight_reg_inactive, 16'h05C0);
    chk("ld_pe11_act",   dut.pe11.weight_reg_active,   16'h0000);
    col_size_valid = 1'b0;
    wt1 = 16'h0100; sw = 1'b1; start = 1'b1; d1 = 16'h0100;
    exp1_q.push_back(16'h0000);
    exp2_q.push_back(16'h0000);
    tick();
    chk("sw_pe11_inact", dut.pe11.weight_reg_inactive, 16'h0100);
    chk("sw_pe11_act",   dut.pe11.weight_reg_active,   16'h05C0);
    chk("sw_pe11_psum",  dut.pe11.pe_psum_out,         16'h0000);
    chk("sw_pe11_in",    dut.pe11.pe_input_out,        16'h0100);
    chk("sw_pe21_inact", dut.pe21.weight_reg_inactive, 16'h05C0);
    idle_inputs();
    repeat (4) tick();

    // Reference matmul, both columns then column 2 disabled.
    ma[0][0] = to_fixed(1); ma[0][1] = to_fixed(2);
    ma[1][0] = to_fixed(5); ma[1][1] = to_fixed(6);
    run_mm(16'h0100, 16'h0459, 16'h05C0, 16'h0100, 2, 16'd2);
    run_mm(16'h0100, 16'h0459, 16'h05C0, 16'h0100, 2, 16'd1);

    // Negative operand and wrap-around overflow.
    ma[0][0] = 16'hFF00; ma[0][1] = 16'h0000;
    ma[1][0] = 16'h7F00; ma[1][1] = 16'h0000;
    run_mm(16'h0200, 16'h0200, 16'h0000, 16'h0100, 2, 16'd2);

    // Randomized matmuls with random column sizes.
    for (int r = 0; r < 12; r++) begin
      logic [15:0] rw[4];
      int unsigned rn;
      rn = $urandom_range(1, 8);
      for (int k = 0; k < 4; k++) rw[k] = 16'($urandom);
      for (int unsigned i = 0; i < rn; i++) begin
        ma[i][0] = 16'($urandom);
        ma[i][1] = 16'($urandom);
      end
      run_mm(rw[0], rw[1], rw[2], rw[3], rn, 16'($urandom_range(0, 3)));
    end

    // Reset mid-stream: everything clears in one edge, pending results are dropped.
    ma[0][0] = to_fixed(3); ma[0][1] = to_fixed(-2);
    idle_inputs();
    col_size_valid = 1'b1; col_size = 16'd2; acc1 = 1'b1; wt1 = 16'h0100;
    tick();
    idle_inputs();
    sw = 1'b1; acc2 = 1'b1; wt2 = 16'h0300;
    tick();
    idle_inputs();
    start = 1'b1; d1 = 16'h0300;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    check_all_zero("midreset");
    chk("midreset_colsize", dut.r_col_size, 16'd0);
    rst = 1'b0;
    exp1_q.delete();
    exp2_q.delete();
    repeat (3) tick();

    ma[0][0] = to_fixed(2); ma[0][1] = to_fixed(3);
    run_mm(to_fixed(1), to_fixed(2), to_fixed(3), to_fixed(4), 1, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
